fft_bitrev_reorder: RTL
=======================

# fft_bitrev_reorder

Frame reorder buffer placed on the output stream of the FFT256 datapath. It accepts one complex result word per cycle in natural (write) order and re-emits each FFT_POINTS-word frame in bit-reversed index order on a ready/valid output. A two-bank ping-pong memory lets one frame fill while the previous frame drains, so it sustains one word per cycle in both directions.

## Interface
- OUTPUT_WIDTH, default from `params.svh`: width of each real/imag component.
- FFT_POINTS, default 256: frame length. Must be a power of two, ≥4.
- LOG2N, default $clog2(FFT_POINTS): index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  buffer can accept a word.
- in_data  in  2*OUTPUT_WIDTH  signed {real, imag}; real in the upper half.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  2*OUTPUT_WIDTH  signed {real, imag}, registered.
- out_last  out  1  high with the final word of each frame.

## Operation
- **Banks:** bank 0 and bank 1, each FFT_POINTS words. Each bank has a `full` flag.
  - Write side: wr_bank, wr_idx.
  - Read side: rd_bank, rd_idx.
- **Accept:** in_ready = !rst && !full[wr_bank]. On in_valid && in_ready:
  - Write mem[wr_bank][wr_idx] ← in_data.
  - Increment wr_idx.
  - At wr_idx == FFT_POINTS-1: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
- **Load:** out register loads when (!out_valid || out_ready) && full[rd_bank].
  - Load out_data ← mem[rd_bank][bitrev(rd_idx)] and out_last ← (rd_idx == FFT_POINTS-1).
  - Set out_valid ← 1 and increment rd_idx.
  - On loading rd_idx == FFT_POINTS-1: clear full[rd_bank], toggle rd_bank, wrap rd_idx to 0.
- If out_ready is high and no load occurs, out_valid ← 0.
- **Bit reversal:** bitrev(i) reverses the LOG2N bits of i. For example, with N=256: 1→128, 2→64, 3→192.
- **Bank states:** EMPTY → FILLING (first write) → FULL (last write) → DRAINING (first load) → EMPTY (last load).
- **Simultaneous set and clear:** a set of full on one bank and a clear on the other bank at the same edge are both applied.
- **Stall behaviour:**
  - Both banks full → in_ready low until the drain of rd_bank completes.
  - out_ready low with out_valid high → out_data and out_last hold stable.
- **Data path:** pure copy. No arithmetic, rounding or saturation is applied to the data.
- **Reset:**
  - rst high clears all flags and indices and sets wr_bank = rd_bank = 0.
  - out_valid, out_last and out_data are 0.
  - in_ready is 0 while rst is high.
  - Reset mid-frame discards any partial or full frames. The first word accepted after reset is index 0 of a new frame.
  - Memory contents are not reset.

## Timing
- Memory read is synchronous: the address is presented and out_data registered in the same load edge.
- **Latency:** if input word FFT_POINTS-1 is accepted at edge k, full is set at edge k. The first output word is loaded at edge k+1, so out_valid is high after k+1.
- **Throughput:** with continuous in_valid and out_ready high, in_ready never deasserts after the first frame.
  - Bank A is cleared at the same edge bank B becomes full.
  - Writes resume into bank A at the next cycle.
- An output transfer and a load in the same cycle give one word per cycle with no bubble.
- Outputs after reset deassertion: in_ready = 1 on the first cycle; out_valid = 0 until a frame completes.

## Structure
- Shared package `params.svh` holds:
  - OUTPUT_WIDTH and FFT_POINTS.
  - The complex sample typedef, packed {real, imag}.
  - An automatic `bitrev` function, parameterised on LOG2N.
- Sub-module `fft_pingpong_ram` implements the two-bank, single-write, single-read RAM with a bank-select bit in the address and a synchronous registered read. This allows it to map to block RAM.
- Control (flags, indices, output register) lives in `fft_bitrev_reorder`.

## Test plan
- **Single frame:** real=i, imag=-i for i=0..255, out_ready=1.
  - Outputs are indices 0, 128, 64, 192, …, 255.
  - out_last is high only on the index 255 word.
  - First out_valid occurs one cycle after the last accept.
- **Four back-to-back frames:** in_valid and out_ready held high.
  - in_ready stays high throughout.
  - 1024 outputs, each frame bit-reversed.
  - Frames 0–3 appear in order.
- **Output stalled:** out_ready=0 from reset.
  - Exactly 512 words are accepted, then in_ready=0.
  - out_valid=1 with out_data = frame 0, index 0, held stable.
  - Releasing out_ready drains 512 words correctly.
- **Random backpressure:** random in_valid and out_ready (50%) over 20 frames.
  - A scoreboard confirms bit-reversed order with no loss or duplication.
  - out_data is stable whenever out_valid && !out_ready.
- **Reset mid-frame:** rst after 100 words are accepted.
  - out_valid=0 and out_data=0.
  - The next 256 words form a complete frame starting at index 0.
- **Reset mid-drain:** rst while out_valid=1 and frame 0 is half read.
  - No further output occurs from the old frames.
  - in_ready=1 on the cycle after rst falls.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, complex sample type and bit-reversal helper for the FFT
// output reorder buffer.
package fft_bitrev_reorder_pkg;

    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_FFT_POINTS   = 256;
    localparam int IDX_MAX_W        = 16;

    typedef struct packed {
        logic signed [DEF_OUTPUT_WIDTH-1:0] re;
        logic signed [DEF_OUTPUT_WIDTH-1:0] im;
    } cplx_t;

    // Reverses the low log2n bits of idx by shifting them out LSB-first.
    function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] idx,
                                                    input int log2n);
        logic [IDX_MAX_W-1:0] r;
        logic [IDX_MAX_W-1:0] s;
        r = '0;
        s = idx;
        for (int b = 0; b < IDX_MAX_W; b++) begin
            if (b < log2n) begin
                r = {r[IDX_MAX_W-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Input/output streaming handshake of the reorder buffer; slave is the buffer's
// view, master is the view of whatever drives and consumes it.
interface fft_bitrev_reorder_if #(
    parameter int OUTPUT_WIDTH = fft_bitrev_reorder_pkg::DEF_OUTPUT_WIDTH
);
    logic                             in_valid;
    logic                             in_ready;
    logic signed [2*OUTPUT_WIDTH-1:0] in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [2*OUTPUT_WIDTH-1:0] out_data;
    logic                             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank simple dual-port RAM: bank select is the address MSB, read data is
// registered so the array maps onto block RAM.
module fft_pingpong_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic signed [DATA_W-1:0] o_rdata
);
    logic signed [DATA_W-1:0] r_mem [2**ADDR_W];
    logic signed [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is cleared; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer: writes each FFT frame in natural order and drains it
// in bit-reversed order while the other bank fills.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int OUTPUT_WIDTH = fft_bitrev_reorder_pkg::DEF_OUTPUT_WIDTH,
    parameter int FFT_POINTS   = fft_bitrev_reorder_pkg::DEF_FFT_POINTS
) (
    input logic                clk,
    input logic                rst,
    fft_bitrev_reorder_if.slave bus
);
    localparam int LOG2N = $clog2(FFT_POINTS);
    localparam int DW    = 2 * OUTPUT_WIDTH;
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(FFT_POINTS - 1);

    logic [1:0]              r_full;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [LOG2N-1:0]        r_wr_idx;
    logic [LOG2N-1:0]        r_rd_idx;
    logic                    r_out_valid;
    logic                    r_out_last;

    logic                    w_acc;
    logic                    w_load;
    logic                    w_wr_last;
    logic                    w_rd_last;
    logic [LOG2N-1:0]        w_rev;
    logic [1:0]              w_full_nxt;
    logic signed [DW-1:0]    w_rd_data;

    assign bus.in_ready = !rst && !r_full[r_wr_bank];
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_wr_last    = (r_wr_idx == IDX_LAST);
    assign w_load       = (!r_out_valid || bus.out_ready) && r_full[r_rd_bank];
    assign w_rd_last    = (r_rd_idx == IDX_LAST);
    assign w_rev        = LOG2N'(bitrev(IDX_MAX_W'(r_rd_idx), LOG2N));

    // Set and clear always target different banks, so both can apply together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_load && w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_acc && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_acc) begin
                r_wr_idx <= r_wr_idx + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_load) begin
                r_rd_idx    <= r_rd_idx + 1'b1;
                r_out_valid <= 1'b1;
                r_out_last  <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    fft_pingpong_ram #(
        .DATA_W (DW),
        .ADDR_W (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_acc),
        .i_waddr ({r_wr_bank, r_wr_idx}),
        .i_wdata (bus.in_data),
        .i_re    (w_load),
        .i_raddr ({r_rd_bank, w_rev}),
        .o_rdata (w_rd_data)
    );

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = w_rd_data;
endmodule
